// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//   Front end for the game core: synchronises and debounces the five board
//   keys and the flag/mine mode switch. Each accepted key press yields one
//   single-cycle pulse on button_o; the switch yields a clean level.
//
//   Bit order on all key vectors: [4] centre, [3] left, [2] right,
//   [1] up, [0] down.
//
//   Ports:
//     clk            system clock
//     rst_n          asynchronous active-low reset
//     key_raw_i[4:0] raw board keys, asynchronous to clk
//     switch_raw_i   raw flag/mine mode switch, asynchronous
//     button_o[4:0]  one-cycle press pulses (registered)
//     button_level_o debounced held level per key, 1 = held (registered)
//     fm_switch_o    debounced switch level (registered)
//
//   Optional feature macro: BUTTON_AUTOREPEAT_EN
//     When defined, the direction keys [3:0] auto-repeat while held:
//     first repeat REPEAT_DELAY cycles after the accepting pulse, then
//     every REPEAT_PERIOD cycles. The centre key never repeats. When not
//     defined, no repeat counters exist and each press pulses once.
// ---------------------------------------------------------------------------

// Debounce FSM for one synchronised channel. Produces a registered level
// and, when PULSE_EN is set, a registered one-cycle pulse on acceptance.
module button_debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter bit PULSE_EN        = 1'b1
`ifdef BUTTON_AUTOREPEAT_EN
    ,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample,
    output logic pulse,
    output logic level
);

    // Wide enough to hold DEBOUNCE_CYCLES itself, so the counter can rest
    // at its terminal value after a transition instead of wrapping.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    state_t           state_r, next_state_s;
    logic [CNT_W-1:0] cnt_r, next_cnt_s;
    logic             level_r, next_level_s;
    logic             pulse_r;
    logic             accept_s;
    logic             rpt_fire_s;

    // Next-state, counter and level decode. The incoming sample is the
    // D-th consecutive one when the counter already holds D-1.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        next_level_s = level_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sample) begin
                    next_state_s = ST_PRESS_WAIT;
                    next_cnt_s   = CNT_ONE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sample) begin
                    next_state_s = ST_IDLE;
                    next_cnt_s   = CNT_ZERO;
                end else if (cnt_r >= CNT_LAST) begin
                    next_state_s = ST_HELD;
                    next_cnt_s   = CNT_FULL;
                    next_level_s = 1'b1;
                    accept_s     = PULSE_EN;
                end else begin
                    next_cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!sample) begin
                    next_state_s = ST_RELEASE_WAIT;
                    next_cnt_s   = CNT_ONE;
                end else begin
                    next_state_s = ST_HELD;
                end
            end
            ST_RELEASE_WAIT: begin
                if (sample) begin
                    // Release bounce: back to held, no new pulse.
                    next_state_s = ST_HELD;
                    next_cnt_s   = CNT_FULL;
                end else if (cnt_r >= CNT_LAST) begin
                    next_state_s = ST_IDLE;
                    next_cnt_s   = CNT_FULL;
                    next_level_s = 1'b0;
                end else begin
                    next_cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                next_cnt_s   = CNT_ZERO;
                next_level_s = 1'b0;
            end
        endcase
    end

    // FSM state, debounce counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
            level_r <= next_level_s;
            pulse_r <= accept_s | rpt_fire_s;
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    generate
        if (REPEAT_EN) begin : g_repeat
            localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int RPT_W   = $clog2(RPT_MAX + 1);

            logic [RPT_W-1:0] rpt_cnt_r;
            logic [RPT_W-1:0] rpt_limit_s;
            logic             rpt_in_delay_r;

            // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
            always_comb begin
                if (rpt_in_delay_r) begin
                    rpt_limit_s = RPT_W'(REPEAT_DELAY);
                end else begin
                    rpt_limit_s = RPT_W'(REPEAT_PERIOD);
                end
            end

            // Fire only while staying in HELD; release-wait suspends repeats.
            always_comb begin
                if ((state_r == ST_HELD) && (next_state_s == ST_HELD) &&
                    (rpt_cnt_r == rpt_limit_s)) begin
                    rpt_fire_s = 1'b1;
                end else begin
                    rpt_fire_s = 1'b0;
                end
            end

            // rpt_cnt_r holds cycles since the last pulse (1 on the pulse edge).
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rpt_cnt_r      <= RPT_W'(0);
                    rpt_in_delay_r <= 1'b1;
                end else if (next_state_s != ST_HELD) begin
                    rpt_cnt_r      <= RPT_W'(0);
                    rpt_in_delay_r <= 1'b1;
                end else if (state_r == ST_PRESS_WAIT) begin
                    rpt_cnt_r      <= RPT_W'(1);
                    rpt_in_delay_r <= 1'b1;
                end else if (state_r == ST_RELEASE_WAIT) begin
                    // Back from a release bounce: period timing, not delay.
                    rpt_cnt_r      <= RPT_W'(1);
                    rpt_in_delay_r <= 1'b0;
                end else if (rpt_fire_s) begin
                    rpt_cnt_r      <= RPT_W'(1);
                    rpt_in_delay_r <= 1'b0;
                end else begin
                    rpt_cnt_r      <= rpt_cnt_r + RPT_W'(1);
                    rpt_in_delay_r <= rpt_in_delay_r;
                end
            end
        end else begin : g_no_repeat
            assign rpt_fire_s = 1'b0;
        end
    endgenerate
`else
    assign rpt_fire_s = 1'b0;
`endif

    assign pulse = pulse_r;
    assign level = level_r;

endmodule

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter bit KEY_ACTIVE_HIGH = 1'b1,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] key_raw_i,
    input  logic       switch_raw_i,
    output logic [4:0] button_o,
    output logic [4:0] button_level_o,
    output logic       fm_switch_o
);

    localparam logic [4:0] KEY_INVERT = KEY_ACTIVE_HIGH ? 5'b00000 : 5'b11111;

    logic [4:0] key_norm_s;
    logic [4:0] key_meta_r;
    logic [4:0] key_sync_r;
    logic       sw_meta_r;
    logic       sw_sync_r;
    logic       sw_pulse_unused_s;

    // Keys are normalised so that 1 always means pressed.
    assign key_norm_s = key_raw_i ^ KEY_INVERT;

    // Two-flop synchronisers; reset value is "not pressed" / switch low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_r <= 5'b00000;
            key_sync_r <= 5'b00000;
            sw_meta_r  <= 1'b0;
            sw_sync_r  <= 1'b0;
        end else begin
            key_meta_r <= key_norm_s;
            key_sync_r <= key_meta_r;
            sw_meta_r  <= switch_raw_i;
            sw_sync_r  <= sw_meta_r;
        end
    end

    generate
        for (genvar k = 0; k < 5; k++) begin : g_key
            button_debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .PULSE_EN        (1'b1)
`ifdef BUTTON_AUTOREPEAT_EN
                ,
                .REPEAT_EN       ((k != 4) ? 1'b1 : 1'b0),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
            ) u_chan (
                .clk    (clk),
                .rst_n  (rst_n),
                .sample (key_sync_r[k]),
                .pulse  (button_o[k]),
                .level  (button_level_o[k])
            );
        end
    endgenerate

    button_debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .PULSE_EN        (1'b0)
`ifdef BUTTON_AUTOREPEAT_EN
        ,
        .REPEAT_EN       (1'b0),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_switch (
        .clk    (clk),
        .rst_n  (rst_n),
        .sample (sw_sync_r),
        .pulse  (sw_pulse_unused_s),
        .level  (fm_switch_o)
    );

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//   Directed self-checking bench for button_conditioner with
//   DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8. Inputs change and
//   outputs are sampled 1 ns after each rising edge. A raw change applied
//   after edge e(-1) shows up on button_o after the 6th following edge.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

    logic       clk;
    logic       rst_n;
    logic [4:0] key_raw_i;
    logic       switch_raw_i;
    logic [4:0] button_o;
    logic [4:0] button_level_o;
    logic       fm_switch_o;

    int checks_total;
    int checks_passed;

    int   pulses;
    int   first_at;
    int   second_at;
    int   last_at;
    logic lvl_all;

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .KEY_ACTIVE_HIGH (1'b1),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .key_raw_i      (key_raw_i),
        .switch_raw_i   (switch_raw_i),
        .button_o       (button_o),
        .button_level_o (button_level_o),
        .fm_switch_o    (fm_switch_o)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run n cycles, recording pulses on bit b and whether level b stayed high.
    task automatic run_count(input int n, input int b, output int np, output int f_at,
                             output int s_at, output int l_at, output logic lall);
        np   = 0;
        f_at = 0;
        s_at = 0;
        l_at = 0;
        lall = 1'b1;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (button_o[b]) begin
                np++;
                if (f_at == 0) f_at = i;
                else if (s_at == 0) s_at = i;
                l_at = i;
            end
            lall = lall & button_level_o[b];
        end
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst_n         = 1'b0;
        key_raw_i     = 5'b00000;
        switch_raw_i  = 1'b0;

        // Reset state
        repeat (3) tick();
        check_eq("reset_button", {27'd0, button_o}, 32'd0);
        check_eq("reset_level", {27'd0, button_level_o}, 32'd0);
        check_eq("reset_fm", {31'd0, fm_switch_o}, 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Clean centre press held 30 cycles, then released
        key_raw_i = 5'b10000;
        run_count(6, 4, pulses, first_at, second_at, last_at, lvl_all);
        check_eq("c_pulse_cnt", pulses, 32'd1);
        check_eq("c_pulse_at", first_at, 32'd6);
        check_eq("c_button_vec", {27'd0, button_o}, 32'h10);
        check_eq("c_level_on", {27'd0, button_level_o}, 32'h10);
        run_count(24, 4, pulses, first_at, second_at, last_at, lvl_all);
        check_eq("c_no_second", pulses, 32'd0);
        check_eq("c_level_held", {31'd0, lvl_all}, 32'd1);
        key_raw_i = 5'b00000;
        run_count(5, 4, pulses, first_at, second_at, last_at, lvl_all);
        check_eq("c_level_rel5", {31'd0, lvl_all}, 32'd1);
        tick();
        check_eq("c_level_off6", {27'd0, button_level_o}, 32'd0);
        check_eq("c_no_rel_pulse", pulses + {31'd0, button_o[4]}, 32'd0);
        repeat (4) tick();

        // Right key bouncing 1,0,1,0 then stable 1
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            key_raw_i[2] = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            if (button_o[2]) pulses++;
        end
        check_eq("b_no_pulse_bounce", pulses, 32'd0);
        key_raw_i[2] = 1'b1;
        run_count(12, 2, pulses, first_at, second_at, last_at, lvl_all);
        check_eq("b_pulse_cnt", pulses, 32'd1);
        check_eq("b_pulse_at", first_at, 32'd6);

        // Release bounce on the held right key: raw low for 2 cycles
        key_raw_i[2] = 1'b0;
        tick();
        tick();
        key_raw_i[2] = 1'b1;
        run_count(6, 2, pulses, first_at, second_at, last_at, lvl_all);
        check_eq("rb_level_kept", {31'd0, lvl_all}, 32'd1);
        check_eq("rb_no_pulse", pulses, 32'd0);
        key_raw_i[2] = 1'b0;
        repeat (8) tick();
        check_eq("rb_level_off", {27'd0, button_level_o}, 32'd0);

        // Left and down on the same edge
        key_raw_i = 5'b01001;
        repeat (5) tick();
        check_eq("s_before", {27'd0, button_o}, 32'd0);
        tick();
        check_eq("s_both", {27'd0, button_o}, 32'h09);
        tick();
        check_eq("s_after", {27'd0, button_o}, 32'd0);
        check_eq("s_levels", {27'd0, button_level_o}, 32'h09);
        repeat (3) tick();
        key_raw_i = 5'b00000;
        repeat (8) tick();

        // Reset while up is held, then re-acceptance after release
        key_raw_i = 5'b00010;
        repeat (8) tick();
        check_eq("r_level_pre", {27'd0, button_level_o}, 32'h02);
        rst_n = 1'b0;
        #1;
        check_eq("r_level_async", {27'd0, button_level_o}, 32'd0);
        check_eq("r_button_async", {27'd0, button_o}, 32'd0);
        tick();
        rst_n = 1'b1;
        run_count(12, 1, pulses, first_at, second_at, last_at, lvl_all);
        check_eq("r_pulse_cnt", pulses, 32'd1);
        check_eq("r_pulse_at", first_at, 32'd6);
        key_raw_i = 5'b00000;
        repeat (8) tick();

        // Mode switch: clean level, never pulses
        switch_raw_i = 1'b1;
        repeat (5) tick();
        check_eq("sw_before", {31'd0, fm_switch_o}, 32'd0);
        tick();
        check_eq("sw_on", {31'd0, fm_switch_o}, 32'd1);
        check_eq("sw_no_button", {27'd0, button_o}, 32'd0);
        switch_raw_i = 1'b0;
        repeat (5) tick();
        check_eq("sw_hold", {31'd0, fm_switch_o}, 32'd1);
        tick();
        check_eq("sw_off", {31'd0, fm_switch_o}, 32'd0);
        repeat (3) tick();

        // Left held 60 cycles
        key_raw_i = 5'b01000;
        run_count(60, 3, pulses, first_at, second_at, last_at, lvl_all);
        check_eq("h3_first", first_at, 32'd6);
`ifdef BUTTON_AUTOREPEAT_EN
        check_eq("h3_count", pulses, 32'd6);
        check_eq("h3_second", second_at, 32'd26);
        check_eq("h3_last", last_at, 32'd58);
`else
        check_eq("h3_count", pulses, 32'd1);
`endif
        key_raw_i = 5'b00000;
        repeat (8) tick();

        // Centre held 60 cycles: never repeats
        key_raw_i = 5'b10000;
        run_count(60, 4, pulses, first_at, second_at, last_at, lvl_all);
        check_eq("h4_first", first_at, 32'd6);
        check_eq("h4_count", pulses, 32'd1);
        key_raw_i = 5'b00000;
        repeat (8) tick();
        check_eq("end_idle", {27'd0, button_level_o}, 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
